// File: rtl/mlp_engine.sv
// Time-multiplexed 3-layer perceptron: per-neuron MAC lanes stream one input per cycle,
// sigmoid via external ROM, argmax over the output layer.
module mlp_engine #(
  parameter int N_IN  = 784,
  parameter int N_HID = 20,
  parameter int N_OUT = 10,
  parameter int DW    = 16,
  parameter int FRAC  = 11,
  parameter int ACC_W = 32
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               Start,
  output logic                               Busy,
  output logic                               Done,
  output logic [$clog2(N_IN)-1:0]            PixAddr,
  input  logic [DW-1:0]                      PixData,
  output logic [$clog2(N_IN+2*N_HID+3)-1:0]  WAddr,
  input  logic [N_HID*DW-1:0]                WData,
  output logic [DW-1:0]                      SigAddr,
  input  logic [DW-1:0]                      SigData,
  output logic [N_OUT*DW-1:0]                Probability,
  output logic [$clog2(N_OUT)-1:0]           Class
);

  localparam int CW  = $clog2(N_IN+2);
  localparam int HW  = $clog2(N_HID);
  localparam int CLW = $clog2(N_OUT);
  localparam int PAW = $clog2(N_IN);
  localparam int WAW = $clog2(N_IN+2*N_HID+3);

  localparam logic signed [ACC_W-1:0] ZMAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ZMIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0]    ONE  = {{(DW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MAC    = 3'd1,
    S_ACT    = 3'd2,
    S_ARGMAX = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                   state_r, state_s;
  logic [1:0]               layer_r, layer_s;
  logic [CW-1:0]            tick_r, tick_s;
  logic                     acc_clr_s;
  logic [CW-1:0]            n_s, m_s;
  logic [WAW-1:0]           base_s;
  logic [HW-1:0]            prev_idx_s;
  logic signed [DW-1:0]     x_s, z_s;
  logic signed [2*DW-1:0]   prod_s [N_HID];
  logic signed [ACC_W-1:0]  term_s [N_HID];
  logic signed [ACC_W-1:0]  acc_r  [N_HID];
  logic [DW-1:0]            act_r  [N_HID];
  logic [DW-1:0]            best_r, cand_s;
  logic [CLW-1:0]           best_idx_r, win_idx_s;
  logic                     upd_s;

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACC_W-1:0] a);
    if (a > ZMAX)      sat_dw = {1'b0, {(DW-1){1'b1}}};
    else if (a < ZMIN) sat_dw = {1'b1, {(DW-1){1'b0}}};
    else               sat_dw = a[DW-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W-1:0] s;
    s = a + b;
    if (a[ACC_W-1] == b[ACC_W-1] && s[ACC_W-1] != a[ACC_W-1])
      sat_add = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sat_add = s;
  endfunction

  // Per-layer geometry, MAC operand selection and argmax compare.
  always_comb begin
    n_s        = (layer_r == 2'd0) ? CW'(N_IN) : CW'(N_HID);
    m_s        = (layer_r == 2'd2) ? CW'(N_OUT) : CW'(N_HID);
    case (layer_r)
      2'd0:    base_s = '0;
      2'd1:    base_s = WAW'(N_IN+1);
      default: base_s = WAW'(N_IN+N_HID+2);
    endcase
    prev_idx_s = HW'(tick_r - 1'b1);
    // Data for tick t arrives on tick t+1, so the bias flag is one tick late too.
    if (tick_r == n_s + 1'b1)  x_s = ONE;
    else if (layer_r == 2'd0)  x_s = PixData;
    else                       x_s = act_r[prev_idx_s];
    for (int k = 0; k < N_HID; k++) begin
      prod_s[k] = x_s * $signed(WData[k*DW +: DW]);
      term_s[k] = ACC_W'(prod_s[k] >>> FRAC);
    end
    cand_s    = act_r[tick_r[HW-1:0]];
    upd_s     = (tick_r == '0) || (cand_s > best_r);
    win_idx_s = upd_s ? CLW'(tick_r) : best_idx_r;
  end

  // Sequencer state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= S_IDLE;
      layer_r <= 2'd0;
      tick_r  <= '0;
    end else begin
      state_r <= state_s;
      layer_r <= layer_s;
      tick_r  <= tick_s;
    end
  end

  // Next-state and address/handshake decode.
  always_comb begin
    state_s   = state_r;
    layer_s   = layer_r;
    tick_s    = tick_r;
    acc_clr_s = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    PixAddr   = '0;
    WAddr     = '0;
    SigAddr   = '0;
    z_s       = '0;
    case (state_r)
      S_IDLE: begin
        if (Start) begin
          state_s   = S_MAC;
          layer_s   = 2'd0;
          tick_s    = '0;
          acc_clr_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_MAC: begin
        Busy = 1'b1;
        if (layer_r == 2'd0 && tick_r < CW'(N_IN)) PixAddr = PAW'(tick_r);
        else                                       PixAddr = '0;
        if (tick_r <= n_s) WAddr = base_s + WAW'(tick_r);
        else               WAddr = '0;
        if (tick_r == n_s + 1'b1) begin
          state_s = S_ACT;
          tick_s  = '0;
        end else begin
          tick_s = tick_r + 1'b1;
        end
      end
      S_ACT: begin
        Busy = 1'b1;
        if (tick_r < m_s) begin
          z_s     = sat_dw(acc_r[tick_r[HW-1:0]]);
          SigAddr = {~z_s[DW-1], z_s[DW-2:0]};
        end else begin
          SigAddr = '0;
        end
        if (tick_r == m_s) begin
          tick_s = '0;
          if (layer_r == 2'd2) begin
            state_s = S_ARGMAX;
          end else begin
            state_s   = S_MAC;
            layer_s   = layer_r + 1'b1;
            acc_clr_s = 1'b1;
          end
        end else begin
          tick_s = tick_r + 1'b1;
        end
      end
      S_ARGMAX: begin
        Busy = 1'b1;
        if (tick_r == CW'(N_OUT-1)) begin
          state_s = S_DONE;
          tick_s  = '0;
        end else begin
          tick_s = tick_r + 1'b1;
        end
      end
      S_DONE: begin
        Done    = 1'b1;
        state_s = S_IDLE;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Lane accumulators: cleared on MAC entry, then one saturating add per tick.
  always_ff @(posedge Clk) begin
    for (int k = 0; k < N_HID; k++) begin
      if (Reset || acc_clr_s)
        acc_r[k] <= '0;
      else if (state_r == S_MAC && tick_r != '0)
        acc_r[k] <= sat_add(acc_r[k], term_s[k]);
    end
  end

  // Activation capture from the sigmoid ROM, one cycle behind its address.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < N_HID; k++) act_r[k] <= '0;
    end else if (state_r == S_ACT && tick_r != '0) begin
      act_r[prev_idx_s] <= SigData;
    end
  end

  // Running argmax; results publish on the edge into DONE so they are valid with Done.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      best_r      <= '0;
      best_idx_r  <= '0;
      Probability <= '0;
      Class       <= '0;
    end else if (state_r == S_ARGMAX) begin
      best_r     <= upd_s ? cand_s : best_r;
      best_idx_r <= win_idx_s;
      if (tick_r == CW'(N_OUT-1)) begin
        for (int k = 0; k < N_OUT; k++) Probability[k*DW +: DW] <= act_r[k];
        Class <= win_idx_s;
      end
    end
  end

endmodule
